// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter owning the select of a shared 4:1 mux.
// A hold counter forces rotation when one requester camps under contention.
module rr_mux4_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    gnt_nxt;
  logic [1:0]    sel_nxt;
  logic [1:0]    ptr;
  logic [1:0]    ptr_nxt;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_nxt;
  logic [3:0]    own;
  logic [3:0]    rest;
  logic [2:0]    win_all;
  logic [2:0]    win_rest;
  logic          do_grant;
  logic [1:0]    win;

  // {found, index}: first set bit searching upward from p+1.
  function automatic logic [2:0] pick(
    input logic [3:0] r,
    input logic [1:0] p
  );
    logic [1:0] idx;
    pick = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k) + 2'd1;
      if (r[idx]) pick = {1'b1, idx};
    end
  endfunction

  assign own      = 4'b0001 << ptr;
  assign rest     = req & ~own;
  assign win_all  = pick(req, ptr);
  assign win_rest = pick(rest, ptr);

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    do_grant  = 1'b0;
    win       = win_all[1:0];
    unique case (state)
      IDLE: begin
        do_grant = win_all[2];
      end
      GRANT: begin
        if (!req[ptr]) begin
          if (win_all[2]) begin
            do_grant = 1'b1;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = 4'b0000;
          end
        end else if ((|rest) && (hold_cnt == HOLD_LAST)) begin
          // owner masked out, so it ends up last in line
          do_grant = 1'b1;
          win      = win_rest[1:0];
        end else if (hold_cnt != HOLD_LAST) begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      default: ;
    endcase
    if (do_grant) begin
      state_nxt = GRANT;
      gnt_nxt   = 4'b0001 << win;
      sel_nxt   = win;
      ptr_nxt   = win;
      hold_nxt  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      sel      <= 2'd0;
      ptr      <= 2'd3;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    out = in0;
    unique case (sel)
      2'd0: out = in0;
      2'd1: out = in1;
      2'd2: out = in2;
      2'd3: out = in3;
      default: out = in0;
    endcase
  end

  assign out_valid = |gnt;

endmodule
